life_window_gen: RTL and testbench

- Upstream neighbourhood generator for the Game-of-Life cell-update stage.
- Accepts a row-major serial stream of cell states, one bit per cell, for a W x H grid.
- Emits, for each cell in row-major order, a registered 3x3 window: the eight neighbours (Tl, T, Tr, L, R, Bl, B, Br) and the centre C.
- The eight neighbour bits feed the neighbour-count/rule logic directly; cells outside the grid read as dead (zero padding).

---
 rtl/life_window_gen.sv | 174 +++++++++++++++++
 tb/tb_life_window_gen.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_window_gen.sv
// Game-of-Life 3x3 neighbourhood generator: serial row-major cells in, registered windows out.
// Optional NEIGHBOR_COUNT_EN adds a registered 4-bit neighbour population count (out_count).
module life_window_gen #(
   parameter int unsigned W = 16,
   parameter int unsigned H = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_cell,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   Tl,
   output logic                   T,
   output logic                   Tr,
   output logic                   L,
   output logic                   R,
   output logic                   Bl,
   output logic                   B,
   output logic                   Br,
   output logic                   C,
   output logic [$clog2(W)-1:0]   out_x,
   output logic [$clog2(H)-1:0]   out_y,
   output logic                   frame_last
`ifdef NEIGHBOR_COUNT_EN
   ,
   output logic [3:0]             out_count
`endif
);

   localparam int unsigned XW = $clog2(W);
   localparam int unsigned YW = $clog2(H);
   localparam int unsigned NW = $clog2(W * H);
   // Oldest 2W+2 cells are stored; the cell shifting in this cycle completes the 2W+3 window.
   localparam int unsigned HD = 2 * W + 2;

   typedef enum logic [1:0] {StFill, StRun, StFlush} state_e;

   state_e          state_q, state_d;
   logic [HD-1:0]   hist_q;
   logic [HD:0]     hist_next;
   logic [NW-1:0]   in_cnt_q;
   logic [XW-1:0]   cx_q;
   logic [YW-1:0]   cy_q;
   logic            free, accept, load, shift, shift_bit;
   logic            first_col, last_col, first_row, last_row;
   logic            m_tl, m_t, m_tr, m_l, m_c, m_r, m_bl, m_b, m_br;

   assign free   = !out_valid || out_ready;
   assign accept = in_valid && in_ready;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= StFill;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StFill:  if (accept && in_cnt_q == NW'(W)) state_d = StRun;
         StRun:   if (accept && in_cnt_q == NW'(W * H - 1)) state_d = StFlush;
         StFlush: if (load && last_col && last_row) state_d = StFill;
         default: state_d = StFill;
      endcase
   end

   // FSM outputs
   always_comb begin
      in_ready  = 1'b0;
      load      = 1'b0;
      shift     = 1'b0;
      shift_bit = in_cell;
      if (rst_n) begin
         unique case (state_q)
            StFill: begin
               in_ready = 1'b1;
               shift    = in_valid;
            end
            StRun: begin
               in_ready = free;
               shift    = in_valid && free;
               load     = in_valid && free;
            end
            StFlush: begin
               shift     = free;
               load      = free;
               shift_bit = 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Input counter, centre coordinates and history
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_cnt_q <= '0;
         cx_q     <= '0;
         cy_q     <= '0;
         hist_q   <= '0;
      end else begin
         if (accept) begin
            in_cnt_q <= (in_cnt_q == NW'(W * H - 1)) ? '0 : in_cnt_q + 1'b1;
         end
         if (shift) hist_q <= hist_next[HD-1:0];
         if (load) begin
            if (last_col) begin
               cx_q <= '0;
               cy_q <= last_row ? '0 : cy_q + 1'b1;
            end else begin
               cx_q <= cx_q + 1'b1;
            end
         end
      end
   end

   assign hist_next = {hist_q, shift_bit};

   assign first_col = (cx_q == '0);
   assign last_col  = (cx_q == XW'(W - 1));
   assign first_row = (cy_q == '0);
   assign last_row  = (cy_q == YW'(H - 1));

   // Taps relative to newest cell q+W+1 at bit 0, masked at the grid edges
   always_comb begin
      m_br = hist_next[0]       && !last_col  && !last_row;
      m_b  = hist_next[1]       && !last_row;
      m_bl = hist_next[2]       && !first_col && !last_row;
      m_r  = hist_next[W]       && !last_col;
      m_c  = hist_next[W+1];
      m_l  = hist_next[W+2]     && !first_col;
      m_tr = hist_next[2*W]     && !last_col  && !first_row;
      m_t  = hist_next[2*W+1]   && !first_row;
      m_tl = hist_next[2*W+2]   && !first_col && !first_row;
   end

   // Output register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         frame_last <= 1'b0;
         {Tl, T, Tr, L, C, R, Bl, B, Br} <= '0;
         out_x      <= '0;
         out_y      <= '0;
      end else if (load) begin
         out_valid  <= 1'b1;
         frame_last <= last_col && last_row;
         {Tl, T, Tr, L, C, R, Bl, B, Br} <= {m_tl, m_t, m_tr, m_l, m_c, m_r, m_bl, m_b, m_br};
         out_x      <= cx_q;
         out_y      <= cy_q;
      end else if (out_ready) begin
         out_valid  <= 1'b0;
         frame_last <= 1'b0;
      end
   end

`ifdef NEIGHBOR_COUNT_EN
   logic [3:0] count_d;

   always_comb begin
      count_d = 4'(m_tl) + 4'(m_t) + 4'(m_tr) + 4'(m_l) + 4'(m_r) + 4'(m_bl) + 4'(m_b)
              + 4'(m_br);
   end

   always_ff @(posedge clk) begin
      if (!rst_n)    out_count <= '0;
      else if (load) out_count <= count_d;
   end
`endif

endmodule

// File: tb/tb_life_window_gen.sv
// Scoreboard bench for life_window_gen (W=H=4): grid-level reference model, random stimulus.
module tb_life_window_gen;
   localparam int unsigned W = 4;
   localparam int unsigned H = 4;
   localparam int unsigned N = W * H;

   typedef struct packed {
      logic [8:0] win;   // {Tl,T,Tr,L,C,R,Bl,B,Br}
      logic [1:0] x;
      logic [1:0] y;
      logic       last;
      logic [3:0] cnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_cell = 1'b0;
   logic       out_ready = 1'b1;
   logic       in_ready, out_valid, frame_last;
   logic       Tl, T, Tr, L, R, Bl, B, Br, C;
   logic [1:0] out_x, out_y;
`ifdef NEIGHBOR_COUNT_EN
   logic [3:0] out_count;
`endif

   life_window_gen #(.W(W), .H(H)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_cell(in_cell),
      .out_valid(out_valid), .out_ready(out_ready),
      .Tl(Tl), .T(T), .Tr(Tr), .L(L), .R(R), .Bl(Bl), .B(B), .Br(Br), .C(C),
      .out_x(out_x), .out_y(out_y), .frame_last(frame_last)
`ifdef NEIGHBOR_COUNT_EN
      , .out_count(out_count)
`endif
   );

   always #5 clk = ~clk;

   int   total = 0;
   int   bad = 0;
   exp_t sbq[$];
   bit   grid[N];
   bit   gaps_en = 0;
   bit   rand_ready = 0;
   bit   stall_arm = 0;
   int   blocked = 0;

   logic [8:0]  dut_win;
   logic [13:0] dut_snap;
   assign dut_win  = {Tl, T, Tr, L, C, R, Bl, B, Br};
   assign dut_snap = {dut_win, out_x, out_y, frame_last};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic bit cell_at(input int x, input int y);
      if (x < 0 || x >= int'(W) || y < 0 || y >= int'(H)) return 1'b0;
      return grid[y * W + x];
   endfunction

   function automatic exp_t model(input int q);
      exp_t e;
      int   x, y;
      x = q % W;
      y = q / W;
      e.win = {cell_at(x-1, y-1), cell_at(x, y-1), cell_at(x+1, y-1),
               cell_at(x-1, y),   cell_at(x, y),   cell_at(x+1, y),
               cell_at(x-1, y+1), cell_at(x, y+1), cell_at(x+1, y+1)};
      e.x    = 2'(x);
      e.y    = 2'(y);
      e.last = (q == int'(N) - 1);
      e.cnt  = 4'($countones(e.win) - int'(e.win[4]));
      return e;
   endfunction

   // Monitor: scoreboard pop on handshake, hold check under backpressure
   bit          held = 0;
   logic [13:0] held_snap;
   always @(negedge clk) begin
      if (!rst_n) begin
         held = 0;
      end else begin
         if (in_valid && !in_ready) blocked++;
         if (held) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(dut_snap), 32'(held_snap));
         end
         if (out_valid && !out_ready) begin
            held = 1;
            held_snap = dut_snap;
         end else begin
            held = 0;
         end
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               check("unexpected_window", 32'(out_valid), 32'd0);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               check("win", 32'(dut_win), 32'(e.win));
               check("out_x", 32'(out_x), 32'(e.x));
               check("out_y", 32'(out_y), 32'(e.y));
               check("frame_last", 32'(frame_last), 32'(e.last));
`ifdef NEIGHBOR_COUNT_EN
               check("out_count", 32'(out_count), 32'(e.cnt));
`endif
            end
         end
      end
   end

   // Consumer: random or always-ready, with one armed 5-cycle stall at window (2,1)
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (stall_arm && out_valid && out_x == 2'd2 && out_y == 2'd1) begin
            logic [13:0] snap;
            stall_arm = 0;
            snap = dut_snap;
            out_ready = 1'b0;
            repeat (5) begin
               @(negedge clk);
               check("stall_in_ready", 32'(in_ready), 32'd0);
               check("stall_hold", 32'(dut_snap), 32'(snap));
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end else begin
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
      end
   end

   task automatic send_cell(input bit c);
      bit acc;
      int tmo;
      if (gaps_en && $urandom_range(0, 3) == 0) begin
         in_valid = 1'b0;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b1;
      in_cell  = c;
      acc = 0;
      tmo = 0;
      while (!acc && tmo < 200) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         tmo++;
      end
      if (!acc) check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   // Push expectations for every window fully determined by the first n cells, then send them
   task automatic send_frame(input int n);
      int last_q;
      last_q = (n == int'(N)) ? int'(N) - 1 : n - int'(W) - 2;
      for (int q = 0; q <= last_q; q++) sbq.push_back(model(q));
      for (int i = 0; i < n; i++) send_cell(grid[i]);
   endtask

   task automatic drain();
      int tmo;
      tmo = 0;
      while ((sbq.size() != 0 || out_valid) && tmo < 1000) begin
         @(posedge clk);
         #1;
         tmo++;
      end
      check("drain_left", 32'(sbq.size()), 32'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      check("post_rst_out_valid", 32'(out_valid), 32'd0);
      check("post_rst_frame_last", 32'(frame_last), 32'd0);
      check("post_rst_window", 32'(dut_win), 32'd0);
      check("post_rst_xy", 32'({out_x, out_y}), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic fill_grid(input int mode);
      for (int i = 0; i < int'(N); i++) begin
         case (mode)
            0:       grid[i] = 1'b0;
            1:       grid[i] = 1'b1;
            2:       grid[i] = (i == 6);
            default: grid[i] = 1'($urandom_range(0, 1));
         endcase
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();

      // All ones, continuous input: first window the cycle after the 6th accept
      fill_grid(1);
      fork
         send_frame(N);
         for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            check("latency", 32'(out_valid), 32'(k - 1 >= int'(W) + 2));
         end
      join
      drain();

      // Single live cell at (2,1)
      fill_grid(2);
      send_frame(N);
      drain();

      // Backpressure at window (2,1)
      fill_grid(1);
      stall_arm = 1;
      send_frame(N);
      drain();
      check("stall_taken", 32'(stall_arm), 32'd0);

      // Back-to-back frames: in_ready low only during the W+1 flush emissions
      blocked = 0;
      fill_grid(1);
      send_frame(N);
      fill_grid(0);
      send_frame(N);
      drain();
      check("flush_blocked", 32'(blocked), 32'(W + 1));

      // Reset after 7 accepts, then a clean all-ones frame
      fill_grid(1);
      send_frame(7);
      drain();
      do_reset();
      check("sb_empty_after_reset", 32'(sbq.size()), 32'd0);
      send_frame(N);
      drain();

      // Random frames, random input gaps and consumer stalls
      gaps_en = 1;
      rand_ready = 1;
      for (int f = 0; f < 6; f++) begin
         fill_grid(3);
         send_frame(N);
      end
      drain();
      rand_ready = 0;
      gaps_en = 0;
      repeat (3) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
